// File: rtl/uart_pkg.sv
// Shared types and helpers for the parametrised UART receiver:
// receiver state encoding, parity mode constants and small combinational helpers.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        PAR   = 3'd3,
        STOP  = 3'd4,
        WRITE = 3'd5
    } rx_state_t;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_ODD  = 1;
    localparam int PARITY_EVEN = 2;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((32'sd1 <<< i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// First-word-fall-through FIFO: the head entry is visible on dout while not empty.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int WIDTH = 10,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  logic                   pop,
    input  logic [WIDTH-1:0]       din,
    output logic [WIDTH-1:0]       dout,
    output logic                   full,
    output logic                   empty,
    output logic [clog2(DEPTH):0]  count
);

    localparam int PW = clog2(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PW-1:0]    wr_ptr_r;
    logic [PW-1:0]    rd_ptr_r;
    logic [PW:0]      count_r;
    logic             do_push_s;
    logic             do_pop_s;

    assign empty = (count_r == {(PW+1){1'b0}});
    assign full  = (count_r == (PW+1)'(DEPTH));
    assign count = count_r;
    assign dout  = empty ? {WIDTH{1'b0}} : mem_r[rd_ptr_r];

    // Accept/pop qualification; a full FIFO can still take a word if it drains one.
    always_comb begin
        do_pop_s  = pop & ~empty;
        do_push_s = push & (~full | do_pop_s);
    end

    // Storage, wrapping pointers and occupancy.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_r <= {PW{1'b0}};
            rd_ptr_r <= {PW{1'b0}};
            count_r  <= {(PW+1){1'b0}};
        end else begin
            if (do_push_s) begin
                mem_r[wr_ptr_r] <= din;
                wr_ptr_r        <= wr_ptr_r + PW'(1);
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + PW'(1);
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + (PW+1)'(1);
                2'b01:   count_r <= count_r - (PW+1)'(1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/uart_rx_param.sv
// Oversampling UART receiver with configurable frame format, optional 2-of-3 bit
// voting and a FWFT word FIFO carrying per-word parity/framing error flags.
module uart_rx_param
    import uart_pkg::*;
#(
    parameter int TICKS_PER_BIT = 16,
    parameter int DATA_BITS     = 8,
    parameter int PARITY        = 0,
    parameter int STOP_BITS     = 1,
    parameter int FIFO_DEPTH    = 4,
    parameter int MAJORITY      = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 serin,
    input  logic                 host_rd,
    output logic [DATA_BITS-1:0] host_dout,
    output logic                 host_perr,
    output logic                 host_ferr,
    output logic                 host_dor,
    output logic                 host_ovr,
    output logic                 cts
);

    localparam int CW      = clog2(TICKS_PER_BIT);
    localparam int BW      = clog2(DATA_BITS + 1);
    localparam int NW      = clog2(FIFO_DEPTH) + 1;
    localparam int FW      = DATA_BITS + 2;
    localparam int MID     = TICKS_PER_BIT / 2 - 1;
    localparam int RESOLVE = (MAJORITY != 0) ? MID + 1 : MID;
    localparam logic PAR_ODD = (PARITY == PARITY_ODD) ? 1'b1 : 1'b0;

    rx_state_t            state_r;
    rx_state_t            state_nxt_s;
    logic                 sync1_r;
    logic                 sync2_r;
    logic                 prev_r;
    logic [CW-1:0]        tick_r;
    logic [BW-1:0]        bit_cnt_r;
    logic                 stop_cnt_r;
    logic [DATA_BITS-1:0] data_r;
    logic                 perr_r;
    logic                 ferr_r;
    logic                 vote_a_r;
    logic                 vote_b_r;
    logic                 ovr_r;
    logic                 cts_r;
    logic                 fall_s;
    logic                 bit_end_s;
    logic                 at_sample_s;
    logic                 sample_s;
    logic                 push_s;
    logic                 pop_s;
    logic [FW-1:0]        fifo_dout_s;
    logic                 fifo_full_s;
    logic                 fifo_empty_s;
    logic [NW-1:0]        fifo_count_s;
    logic [NW-1:0]        free_s;

    assign fall_s      = prev_r & ~sync2_r;
    assign bit_end_s   = (tick_r == CW'(TICKS_PER_BIT - 1));
    assign at_sample_s = (tick_r == CW'(RESOLVE));
    assign sample_s    = (MAJORITY != 0) ? majority3(vote_a_r, vote_b_r, sync2_r) : sync2_r;
    assign push_s      = (state_r == WRITE);
    assign pop_s       = host_rd & ~fifo_empty_s;
    assign free_s      = NW'(FIFO_DEPTH) - fifo_count_s;

    // Two-flop synchroniser plus a delayed copy for start-edge detection.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_r <= 1'b1;
            sync2_r <= 1'b1;
            prev_r  <= 1'b1;
        end else begin
            sync1_r <= serin;
            sync2_r <= sync1_r;
            prev_r  <= sync2_r;
        end
    end

    // Oversampling tick counter, restarted on each state change and bit end.
    always_ff @(posedge clk) begin
        if (reset || (state_nxt_s != state_r) || bit_end_s) begin
            tick_r <= {CW{1'b0}};
        end else begin
            tick_r <= tick_r + CW'(1);
        end
    end

    // Early vote samples; the third vote is the live sample at the resolve tick.
    always_ff @(posedge clk) begin
        if (reset) begin
            vote_a_r <= 1'b1;
            vote_b_r <= 1'b1;
        end else begin
            if (tick_r == CW'(MID - 1)) vote_a_r <= sync2_r;
            if (tick_r == CW'(MID))     vote_b_r <= sync2_r;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state_r <= IDLE;
        else       state_r <= state_nxt_s;
    end

    // Next-state logic; the final stop sample leaves immediately so frames can abut.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (fall_s) state_nxt_s = START;
                else        state_nxt_s = IDLE;
            end
            START: begin
                if (at_sample_s && sample_s) state_nxt_s = IDLE;
                else if (bit_end_s)          state_nxt_s = DATA;
                else                         state_nxt_s = START;
            end
            DATA: begin
                if (bit_end_s && (bit_cnt_r == BW'(DATA_BITS)))
                    state_nxt_s = (PARITY != PARITY_NONE) ? PAR : STOP;
                else
                    state_nxt_s = DATA;
            end
            PAR: begin
                if (bit_end_s) state_nxt_s = STOP;
                else           state_nxt_s = PAR;
            end
            STOP: begin
                if (at_sample_s && (stop_cnt_r == 1'(STOP_BITS - 1))) state_nxt_s = WRITE;
                else                                                 state_nxt_s = STOP;
            end
            WRITE:   state_nxt_s = IDLE;
            default: state_nxt_s = IDLE;
        endcase
    end

    // Frame datapath: LSB-first shift register, bit/stop counters, error accumulators.
    always_ff @(posedge clk) begin
        if (reset) begin
            data_r     <= {DATA_BITS{1'b0}};
            bit_cnt_r  <= {BW{1'b0}};
            stop_cnt_r <= 1'b0;
            perr_r     <= 1'b0;
            ferr_r     <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (fall_s) begin
                        bit_cnt_r  <= {BW{1'b0}};
                        stop_cnt_r <= 1'b0;
                        perr_r     <= 1'b0;
                        ferr_r     <= 1'b0;
                    end
                end
                DATA: begin
                    if (at_sample_s) begin
                        data_r    <= {sample_s, data_r[DATA_BITS-1:1]};
                        bit_cnt_r <= bit_cnt_r + BW'(1);
                    end
                end
                PAR: begin
                    if (at_sample_s) perr_r <= sample_s ^ (^data_r) ^ PAR_ODD;
                end
                STOP: begin
                    if (at_sample_s) begin
                        if (!sample_s) ferr_r <= 1'b1;
                        stop_cnt_r <= stop_cnt_r + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Sticky overrun (a new drop wins over a clearing pop) and registered flow control.
    always_ff @(posedge clk) begin
        if (reset) begin
            ovr_r <= 1'b0;
            cts_r <= 1'b1;
        end else begin
            if (push_s && fifo_full_s && !pop_s) ovr_r <= 1'b1;
            else if (pop_s)                      ovr_r <= 1'b0;
            else                                 ovr_r <= ovr_r;
            cts_r <= (free_s >= NW'(2));
        end
    end

    uart_rx_fifo #(
        .WIDTH (FW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push_s),
        .pop   (host_rd),
        .din   ({ferr_r, perr_r, data_r}),
        .dout  (fifo_dout_s),
        .full  (fifo_full_s),
        .empty (fifo_empty_s),
        .count (fifo_count_s)
    );

    assign host_dout = fifo_dout_s[DATA_BITS-1:0];
    assign host_perr = fifo_dout_s[DATA_BITS];
    assign host_ferr = fifo_dout_s[DATA_BITS+1];
    assign host_dor  = ~fifo_empty_s;
    assign host_ovr  = ovr_r;
    assign cts       = cts_r;

endmodule

// File: tb/tb_uart_rx_param.sv
// Directed bench: an 8N1 receiver (16 ticks, voting) and a 7E2 receiver
// (8 ticks, single sample) driven with hand-built serial frames.
module tb_uart_rx_param;

    logic       clk;
    logic       reset_a, reset_b;
    logic       serin_a, serin_b;
    logic       rd_a, rd_b;
    logic [7:0] dout_a;
    logic [6:0] dout_b;
    logic       perr_a, ferr_a, dor_a, ovr_a, cts_a;
    logic       perr_b, ferr_b, dor_b, ovr_b, cts_b;
    int         checks;
    int         failures;

    uart_rx_param #(
        .TICKS_PER_BIT(16), .DATA_BITS(8), .PARITY(0),
        .STOP_BITS(1), .FIFO_DEPTH(4), .MAJORITY(1)
    ) dut_a (
        .clk(clk), .reset(reset_a), .serin(serin_a), .host_rd(rd_a),
        .host_dout(dout_a), .host_perr(perr_a), .host_ferr(ferr_a),
        .host_dor(dor_a), .host_ovr(ovr_a), .cts(cts_a)
    );

    uart_rx_param #(
        .TICKS_PER_BIT(8), .DATA_BITS(7), .PARITY(2),
        .STOP_BITS(2), .FIFO_DEPTH(4), .MAJORITY(0)
    ) dut_b (
        .clk(clk), .reset(reset_b), .serin(serin_b), .host_rd(rd_b),
        .host_dout(dout_b), .host_perr(perr_b), .host_ferr(ferr_b),
        .host_dor(dor_b), .host_ovr(ovr_b), .cts(cts_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input bit sel_b, input logic v);
        if (sel_b) serin_b = v;
        else       serin_a = v;
    endtask

    task automatic send(input bit sel_b, input logic [8:0] data, input int nbits,
                        input bit has_par, input logic par, input int nstop,
                        input logic stop_val, input int tpb);
        drive(sel_b, 1'b0);
        repeat (tpb) @(negedge clk);
        for (int i = 0; i < nbits; i++) begin
            drive(sel_b, data[i]);
            repeat (tpb) @(negedge clk);
        end
        if (has_par) begin
            drive(sel_b, par);
            repeat (tpb) @(negedge clk);
        end
        for (int i = 0; i < nstop; i++) begin
            drive(sel_b, stop_val);
            repeat (tpb) @(negedge clk);
        end
    endtask

    task automatic pop(input bit sel_b);
        if (sel_b) rd_b = 1'b1;
        else       rd_a = 1'b1;
        @(negedge clk);
        rd_a = 1'b0;
        rd_b = 1'b0;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        reset_a  = 1'b1;
        reset_b  = 1'b1;
        serin_a  = 1'b1;
        serin_b  = 1'b1;
        rd_a     = 1'b0;
        rd_b     = 1'b0;
        repeat (4) @(negedge clk);
        reset_a = 1'b0;
        reset_b = 1'b0;
        @(negedge clk);

        check("rst_dor",  32'(dor_a),  32'h0);
        check("rst_ovr",  32'(ovr_a),  32'h0);
        check("rst_perr", 32'(perr_a), 32'h0);
        check("rst_ferr", 32'(ferr_a), 32'h0);
        check("rst_dout", 32'(dout_a), 32'h0);
        check("rst_cts",  32'(cts_a),  32'h1);

        // 0xA5, 8N1: stop sample resolves 155 cycles after the start edge is driven
        fork
            send(1'b0, 9'h0A5, 8, 1'b0, 1'b0, 1, 1'b1, 16);
            begin
                repeat (156) @(negedge clk);
                check("lat_before", 32'(dor_a), 32'h0);
                @(negedge clk);
                check("lat_dor", 32'(dor_a), 32'h1);
            end
        join
        check("a5_dout", 32'(dout_a), 32'hA5);
        check("a5_perr", 32'(perr_a), 32'h0);
        check("a5_ferr", 32'(ferr_a), 32'h0);
        pop(1'b0);
        check("a5_pop_dor", 32'(dor_a), 32'h0);

        // glitches on an idle line
        drive(1'b0, 1'b0);
        @(negedge clk);
        drive(1'b0, 1'b1);
        repeat (40) @(negedge clk);
        check("glitch1_dor", 32'(dor_a), 32'h0);
        drive(1'b0, 1'b0);
        repeat (6) @(negedge clk);
        drive(1'b0, 1'b1);
        repeat (40) @(negedge clk);
        check("glitch6_dor", 32'(dor_a), 32'h0);

        // framing error and break
        send(1'b0, 9'h03C, 8, 1'b0, 1'b0, 1, 1'b0, 16);
        drive(1'b0, 1'b1);
        repeat (4) @(negedge clk);
        check("fe_dor",  32'(dor_a),  32'h1);
        check("fe_dout", 32'(dout_a), 32'h3C);
        check("fe_ferr", 32'(ferr_a), 32'h1);
        check("fe_perr", 32'(perr_a), 32'h0);
        pop(1'b0);
        drive(1'b0, 1'b0);
        repeat (192) @(negedge clk);
        drive(1'b0, 1'b1);
        repeat (4) @(negedge clk);
        check("brk_dor",  32'(dor_a),  32'h1);
        check("brk_dout", 32'(dout_a), 32'h0);
        check("brk_ferr", 32'(ferr_a), 32'h1);
        pop(1'b0);
        check("brk_pop_dor", 32'(dor_a), 32'h0);

        // five frames into a four-deep FIFO without reads
        send(1'b0, 9'h011, 8, 1'b0, 1'b0, 1, 1'b1, 16);
        repeat (4) @(negedge clk);
        send(1'b0, 9'h022, 8, 1'b0, 1'b0, 1, 1'b1, 16);
        repeat (4) @(negedge clk);
        check("cts_two", 32'(cts_a), 32'h1);
        send(1'b0, 9'h033, 8, 1'b0, 1'b0, 1, 1'b1, 16);
        repeat (4) @(negedge clk);
        check("cts_three", 32'(cts_a), 32'h0);
        send(1'b0, 9'h044, 8, 1'b0, 1'b0, 1, 1'b1, 16);
        repeat (4) @(negedge clk);
        check("ovr_four", 32'(ovr_a), 32'h0);
        send(1'b0, 9'h055, 8, 1'b0, 1'b0, 1, 1'b1, 16);
        repeat (4) @(negedge clk);
        check("ovr_set",  32'(ovr_a),  32'h1);
        check("ovr_head", 32'(dout_a), 32'h11);
        pop(1'b0);
        check("ovr_clr", 32'(ovr_a),  32'h0);
        check("ovr_w2",  32'(dout_a), 32'h22);
        pop(1'b0);
        check("ovr_w3",  32'(dout_a), 32'h33);
        pop(1'b0);
        check("ovr_w4",  32'(dout_a), 32'h44);
        pop(1'b0);
        @(negedge clk);
        check("ovr_empty", 32'(dor_a), 32'h0);
        check("ovr_cts",   32'(cts_a), 32'h1);

        // 7E2 back-to-back frames: 0x35 has four ones, so its even parity bit is 0
        send(1'b1, 9'h035, 7, 1'b1, 1'b1, 2, 1'b1, 8);
        send(1'b1, 9'h035, 7, 1'b1, 1'b0, 2, 1'b1, 8);
        send(1'b1, 9'h05A, 7, 1'b1, 1'b0, 2, 1'b1, 8);
        repeat (4) @(negedge clk);
        check("b1_dout", 32'(dout_b), 32'h35);
        check("b1_perr", 32'(perr_b), 32'h1);
        check("b1_ferr", 32'(ferr_b), 32'h0);
        pop(1'b1);
        check("b2_dout", 32'(dout_b), 32'h35);
        check("b2_perr", 32'(perr_b), 32'h0);
        pop(1'b1);
        check("b3_dout", 32'(dout_b), 32'h5A);
        check("b3_perr", 32'(perr_b), 32'h0);
        check("b3_dor",  32'(dor_b),  32'h1);

        // reset during the data bits of an all-ones frame
        fork
            send(1'b1, 9'h07F, 7, 1'b1, 1'b1, 2, 1'b1, 8);
            begin
                repeat (24) @(negedge clk);
                reset_b = 1'b1;
                repeat (2) @(negedge clk);
                reset_b = 1'b0;
            end
        join
        repeat (10) @(negedge clk);
        check("brst_dor",  32'(dor_b),  32'h0);
        check("brst_dout", 32'(dout_b), 32'h0);
        check("brst_perr", 32'(perr_b), 32'h0);
        check("brst_ferr", 32'(ferr_b), 32'h0);
        check("brst_ovr",  32'(ovr_b),  32'h0);
        check("brst_cts",  32'(cts_b),  32'h1);

        send(1'b1, 9'h02A, 7, 1'b1, 1'b1, 2, 1'b1, 8);
        repeat (4) @(negedge clk);
        check("b4_dor",  32'(dor_b),  32'h1);
        check("b4_dout", 32'(dout_b), 32'h2A);
        check("b4_perr", 32'(perr_b), 32'h0);
        check("b4_ferr", 32'(ferr_b), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
